keypad_scan_ctrl: RTL and testbench

//  Scans the 4x4 calculator keypad: drives one column low at a time, samples
//  the rows, debounces, and hands the main FSM one 4-bit key code per physical

---
 rtl/kb_pkg.sv | 51 +++++
 rtl/kb_tick_gen.sv | 38 +++
 rtl/keypad_scan_ctrl.sv | 176 +++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : kb_pkg
//  Description : Shared definitions for the 4x4 keypad scanner. Holds the
//                scanner state encoding, the key-code constants that the main
//                calculator FSM also imports, and the (row,col) -> code table.
//  Revision    : 1.0  initial release
// ============================================================================
package kb_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } kb_state_t;

    // Operator and symbol keys
    localparam logic [3:0] KEY_ADD  = 4'hA;
    localparam logic [3:0] KEY_SUB  = 4'hB;
    localparam logic [3:0] KEY_MUL  = 4'hC;
    localparam logic [3:0] KEY_DIV  = 4'hD;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // Physical layout:  r0: 1 2 3 +   r1: 4 5 6 -   r2: 7 8 9 x   r3: * 0 # /
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = KEY_ADD;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = KEY_SUB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = KEY_MUL;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = 4'h0;
            4'b11_10: code = KEY_HASH;
            default:  code = KEY_DIV;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kb_tick_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : kb_tick_gen
//  Description : Scan prescaler. Counts 0..SCAN_DIV-1 and raises o_tick for
//                the single cycle in which the count sits at SCAN_DIV-1.
//  Ports       : clk     system clock
//                reset   synchronous active-high reset (count -> 0)
//                o_tick  one-cycle scan tick
//  Revision    : 1.0  initial release
// ============================================================================
module kb_tick_gen #(
    parameter int SCAN_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    output logic o_tick
);

    localparam int c_DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);

    logic [c_DIV_W-1:0] r_div_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (r_div_cnt == c_DIV_LAST) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + c_DIV_W'(1);
        end
    end

    assign o_tick = (r_div_cnt == c_DIV_LAST);

endmodule
`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : keypad_scan_ctrl
//  Description : 4x4 keypad scanner. Drives one column low per scan tick,
//                samples synchronised rows, debounces press and release, and
//                emits one key code per physical press as a one-cycle strobe.
//  Ports       : clk         system clock
//                reset       synchronous active-high reset
//                kb_row_in   [3:0] rows, pulled up, low = key closed
//                kb_col_out  [3:0] active-low column drive, one bit low
//                key_code    [3:0] last accepted key, held until next accept
//                key_valid   one-cycle strobe, key_code newly valid
//                key_down    high while the accepted key is held
//  Revision    : 1.0  initial release
// ============================================================================
module keypad_scan_ctrl
    import kb_pkg::*;
#(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] kb_row_in,
    output logic [3:0] kb_col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int c_DBC_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [c_DBC_W-1:0] c_DBC_DONE = c_DBC_W'(DEBOUNCE_CNT);
    localparam logic [c_DBC_W-1:0] c_DBC_ONE  = c_DBC_W'(1);

    logic [3:0]         r_row_meta;
    logic [3:0]         r_row_sync;
    logic               w_tick;
    logic               w_hit;
    logic [1:0]         w_hit_row;
    logic               w_same_row;
    logic               w_rows_clear;
    logic [1:0]         w_col_next;
    logic [c_DBC_W-1:0] w_dbc_inc;

    kb_state_t          r_state;
    logic [1:0]         r_col_idx;
    logic [1:0]         r_row_idx;
    logic [3:0]         r_col_out;
    logic [3:0]         r_key_code;
    logic               r_key_valid;
    logic               r_key_down;
    logic [c_DBC_W-1:0] r_dbc;

    // Two-flop synchroniser; idle rows read as all-high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= kb_row_in;
            r_row_sync <= r_row_meta;
        end
    end

    kb_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .o_tick (w_tick)
    );

    // A hit is exactly one low row; two or more low rows are ambiguous.
    always_comb begin
        w_hit     = 1'b1;
        w_hit_row = 2'd0;
        case (r_row_sync)
            4'b1110: w_hit_row = 2'd0;
            4'b1101: w_hit_row = 2'd1;
            4'b1011: w_hit_row = 2'd2;
            4'b0111: w_hit_row = 2'd3;
            default: w_hit     = 1'b0;
        endcase
    end

    assign w_same_row   = w_hit && (w_hit_row == r_row_idx);
    assign w_rows_clear = (r_row_sync == 4'hF);
    assign w_col_next   = r_col_idx + 2'd1;
    // r_dbc never exceeds DEBOUNCE_CNT-1 when incremented, so no wrap.
    assign w_dbc_inc    = r_dbc + c_DBC_ONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_SCAN;
            r_col_idx   <= 2'd0;
            r_row_idx   <= 2'd0;
            r_col_out   <= 4'b1110;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_down  <= 1'b0;
            r_dbc       <= '0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    ST_SCAN: begin
                        if (w_hit) begin
                            // Column stays put while the press is qualified.
                            r_row_idx <= w_hit_row;
                            if (DEBOUNCE_CNT == 1) begin
                                r_key_code  <= key_map(w_hit_row, r_col_idx);
                                r_key_valid <= 1'b1;
                                r_key_down  <= 1'b1;
                                r_dbc       <= '0;
                                r_state     <= ST_HELD;
                            end else begin
                                r_dbc   <= c_DBC_ONE;
                                r_state <= ST_DEBOUNCE;
                            end
                        end else begin
                            r_col_idx <= w_col_next;
                            r_col_out <= ~(4'b0001 << w_col_next);
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (w_same_row) begin
                            if (w_dbc_inc == c_DBC_DONE) begin
                                r_key_code  <= key_map(r_row_idx, r_col_idx);
                                r_key_valid <= 1'b1;
                                r_key_down  <= 1'b1;
                                r_dbc       <= '0;
                                r_state     <= ST_HELD;
                            end else begin
                                r_dbc <= w_dbc_inc;
                            end
                        end else begin
                            r_dbc     <= '0;
                            r_state   <= ST_SCAN;
                            r_col_idx <= w_col_next;
                            r_col_out <= ~(4'b0001 << w_col_next);
                        end
                    end
                    ST_HELD: begin
                        // Any low row on the held column restarts release
                        // qualification, so extra keys only delay release.
                        if (w_rows_clear) begin
                            if (w_dbc_inc == c_DBC_DONE) begin
                                r_key_down <= 1'b0;
                                r_dbc      <= '0;
                                r_state    <= ST_SCAN;
                                r_col_idx  <= w_col_next;
                                r_col_out  <= ~(4'b0001 << w_col_next);
                            end else begin
                                r_dbc <= w_dbc_inc;
                            end
                        end else begin
                            r_dbc <= '0;
                        end
                    end
                    default: begin
                        r_dbc   <= '0;
                        r_state <= ST_SCAN;
                    end
                endcase
            end
        end
    end

    assign kb_col_out = r_col_out;
    assign key_code   = r_key_code;
    assign key_valid  = r_key_valid;
    assign key_down   = r_key_down;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scan_ctrl
//  Description : Self-checking bench for keypad_scan_ctrl (SCAN_DIV=4,
//                DEBOUNCE_CNT=3) with a behavioural 4x4 key matrix.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_keypad_scan_ctrl;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  kb_row_in;
    logic [3:0]  kb_col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] pressed;     // bit r*4+c = key at (row r, col c) closed

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .kb_row_in  (kb_row_in),
        .kb_col_out (kb_col_out),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_down   (key_down)
    );

    // Key matrix: a closed key pulls its row low while its column is driven.
    always_comb begin
        kb_row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !kb_col_out[c]) kb_row_in[r] = 1'b0;
            end
        end
    end

    typedef struct {
        int         row;
        int         col;
        logic [3:0] code;
    } key_vec_t;

    key_vec_t   vecs[10];
    logic [3:0] col_seq[5];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first post-reset cycle.
    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (key_valid !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_down_low(input int limit, output int n);
        n = 0;
        while (key_down !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_col(input logic [3:0] col, input int limit);
        int n;
        n = 0;
        while (kb_col_out !== col && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic count_strobes(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (key_valid === 1'b1) cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;

        pressed = '0;
        vecs[0] = '{0, 0, 4'h1};
        vecs[1] = '{0, 3, 4'hA};
        vecs[2] = '{1, 0, 4'h4};
        vecs[3] = '{2, 1, 4'h8};
        vecs[4] = '{3, 0, 4'hE};
        vecs[5] = '{3, 2, 4'hF};
        vecs[6] = '{3, 3, 4'hD};
        vecs[7] = '{2, 3, 4'hC};
        vecs[8] = '{0, 1, 4'h2};
        vecs[9] = '{1, 3, 4'hB};
        col_seq[0] = 4'b1110;
        col_seq[1] = 4'b1101;
        col_seq[2] = 4'b1011;
        col_seq[3] = 4'b0111;
        col_seq[4] = 4'b1110;

        @(negedge clk);

        // 1: reset values and idle column rotation
        pulse_reset();
        chk4("t1_rst_col", kb_col_out, col_seq[0]);
        chk4("t1_rst_code", key_code, 4'h0);
        chk1("t1_rst_valid", key_valid, 1'b0);
        chk1("t1_rst_down", key_down, 1'b0);
        for (int i = 1; i < 5; i++) begin
            repeat (SCAN_DIV) @(negedge clk);
            chk4($sformatf("t1_col_seq%0d", i), kb_col_out, col_seq[i]);
        end
        count_strobes(40, cnt);
        chk_int("t1_idle_strobes", cnt, 0);

        // 2: key 6 (row1, col2), exact latency, single strobe, resume at col3
        pressed[6] = 1'b1;
        pulse_reset();
        wait_valid(200, n);
        chk_int("t2_latency", n, 20);
        chk4("t2_code", key_code, 4'h6);
        chk1("t2_down", key_down, 1'b1);
        @(negedge clk);
        chk1("t2_strobe_one_cycle", key_valid, 1'b0);
        count_strobes(40, cnt);
        chk_int("t2_hold_strobes", cnt, 0);
        chk1("t2_down_held", key_down, 1'b1);
        pressed = '0;
        wait_down_low(200, n);
        chk1("t2_released", key_down, 1'b0);
        chk4("t2_resume_col3", kb_col_out, 4'b0111);

        // Table: every key row/column lands on its mapped code
        foreach (vecs[k]) begin
            pressed = '0;
            pressed[vecs[k].row*4 + vecs[k].col] = 1'b1;
            wait_valid(300, n);
            chk1($sformatf("tbl%0d_strobe", k), key_valid, 1'b1);
            chk4($sformatf("tbl%0d_code", k), key_code, vecs[k].code);
            chk1($sformatf("tbl%0d_down", k), key_down, 1'b1);
            @(negedge clk);
            chk1($sformatf("tbl%0d_one_cycle", k), key_valid, 1'b0);
            count_strobes(30, cnt);
            chk_int($sformatf("tbl%0d_no_repeat", k), cnt, 0);
            pressed = '0;
            wait_down_low(200, n);
            chk1($sformatf("tbl%0d_release", k), key_down, 1'b0);
        end

        // 3: key 0 (row3, col1) bouncing every tick, then clean hold
        pulse_reset();
        cnt = 0;
        for (int cyc = 0; cyc < 96; cyc++) begin
            pressed[13] = ((cyc / 4) % 2) == 1;
            @(negedge clk);
            if (key_valid === 1'b1) cnt++;
        end
        chk_int("t3_bounce_strobes", cnt, 0);
        chk1("t3_bounce_down", key_down, 1'b0);
        pressed[13] = 1'b1;
        wait_valid(300, n);
        chk1("t3_strobe", key_valid, 1'b1);
        chk4("t3_code", key_code, 4'h0);
        pressed = '0;
        wait_down_low(200, n);
        chk1("t3_release", key_down, 1'b0);

        // 4: keys 1 and 7 together on col0 rejected; releasing 7 yields 1
        pressed[0] = 1'b1;
        pressed[8] = 1'b1;
        count_strobes(80, cnt);
        chk_int("t4_multi_strobes", cnt, 0);
        chk1("t4_multi_down", key_down, 1'b0);
        pressed[8] = 1'b0;
        wait_valid(300, n);
        chk1("t4_strobe", key_valid, 1'b1);
        chk4("t4_code", key_code, 4'h1);
        pressed = '0;
        wait_down_low(200, n);
        chk1("t4_release", key_down, 1'b0);

        // 5: key 5 held, key 9 pressed meanwhile; 9 only after 5 released
        pressed[5] = 1'b1;
        wait_valid(300, n);
        chk4("t5_code5", key_code, 4'h5);
        pressed[10] = 1'b1;
        count_strobes(60, cnt);
        chk_int("t5_second_key_strobes", cnt, 0);
        chk1("t5_down_held", key_down, 1'b1);
        chk4("t5_code_kept", key_code, 4'h5);
        pressed[5] = 1'b0;
        wait_valid(300, n);
        chk1("t5_strobe9", key_valid, 1'b1);
        chk4("t5_code9", key_code, 4'h9);
        pressed = '0;
        wait_down_low(200, n);
        chk1("t5_release", key_down, 1'b0);

        // 6a: reset during DEBOUNCE
        pressed[6] = 1'b1;
        wait_col(4'b1101, 100);
        wait_col(4'b1011, 100);
        repeat (6) @(negedge clk);
        pressed = '0;
        pulse_reset();
        chk4("t6a_code", key_code, 4'h0);
        chk1("t6a_valid", key_valid, 1'b0);
        chk1("t6a_down", key_down, 1'b0);
        chk4("t6a_col", kb_col_out, 4'b1110);
        count_strobes(40, cnt);
        chk_int("t6a_strobes", cnt, 0);

        // 6b: reset during HELD
        pressed[6] = 1'b1;
        wait_valid(300, n);
        chk4("t6b_code_before", key_code, 4'h6);
        repeat (10) @(negedge clk);
        pressed = '0;
        pulse_reset();
        chk4("t6b_code", key_code, 4'h0);
        chk1("t6b_down", key_down, 1'b0);
        chk1("t6b_valid", key_valid, 1'b0);
        chk4("t6b_col", kb_col_out, 4'b1110);
        count_strobes(40, cnt);
        chk_int("t6b_strobes", cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
